// File: rtl/unary_to_binary_acc.sv
// Counts the ones of a rate-coded unary product stream over 2^BITWIDTH valid samples
// and hands the saturated binary count to a consumer through a one-entry valid/ready buffer.
module unary_to_binary_acc #(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iStart,
   input  logic                iAbort,
   input  logic                iBit,
   input  logic                iBitVld,
   output logic                oClr,
   output logic                oBusy,
   output logic [BITWIDTH-1:0] oData,
   output logic                oSat,
   output logic                oValid,
   input  logic                iReady
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;

   logic [BITWIDTH-1:0] r_winCnt;
   logic [BITWIDTH:0]   r_onesCnt;
   logic [BITWIDTH-1:0] r_data;
   logic                r_sat;
   logic                r_valid;

   logic                w_acc;
   logic                w_abort;
   logic                w_sample;
   logic                w_last;
   logic                w_handshake;
   logic [BITWIDTH:0]   w_total;

   // Gating with iRstN keeps the RNG clear line quiet while reset is held.
   assign w_acc       = iRstN & iStart &
                        ((r_state == IDLE) | ((r_state == DONE) & iReady));
   assign w_abort     = (r_state == COUNT) & iAbort;
   assign w_sample    = (r_state == COUNT) & iBitVld & ~iAbort;
   assign w_last      = w_sample & (r_winCnt == '1);
   assign w_handshake = (r_state == DONE) & r_valid & iReady;
   assign w_total     = r_onesCnt + {{BITWIDTH{1'b0}}, iBit};

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The unused encoding falls through to IDLE so a corrupted state recovers in one edge.
   always_comb begin
      w_nextState = IDLE;
      case (r_state)
         IDLE: begin
            w_nextState = w_acc ? COUNT : IDLE;
         end
         COUNT: begin
            if (w_abort) begin
               w_nextState = IDLE;
            end else if (w_last) begin
               w_nextState = DONE;
            end else begin
               w_nextState = COUNT;
            end
         end
         DONE: begin
            if (iReady) begin
               w_nextState = w_acc ? COUNT : IDLE;
            end else begin
               w_nextState = DONE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_comb begin
      oBusy = (r_state == COUNT);
      oClr  = w_acc;
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_winCnt  <= '0;
         r_onesCnt <= '0;
      end else if (w_acc | w_abort) begin
         r_winCnt  <= '0;
         r_onesCnt <= '0;
      end else if (w_sample) begin
         r_winCnt  <= r_winCnt + 1'b1;
         r_onesCnt <= w_total;
      end
   end

   // The final sample is folded in through w_total so the result lands on the same edge.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_data  <= '0;
         r_sat   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_last) begin
         r_valid <= 1'b1;
         r_sat   <= w_total[BITWIDTH];
         r_data  <= w_total[BITWIDTH] ? {BITWIDTH{1'b1}} : w_total[BITWIDTH-1:0];
      end else if (w_handshake) begin
         r_valid <= 1'b0;
      end
   end

   assign oData  = r_data;
   assign oSat   = r_sat;
   assign oValid = r_valid;

endmodule

// File: tb/tb_unary_to_binary_acc.sv
// Directed bench for unary_to_binary_acc at BITWIDTH=4: expected counts are queued when a
// window is driven and checked when the result is handed over.
module tb_unary_to_binary_acc;

   localparam int BW = 4;

   logic          iClk;
   logic          iRstN;
   logic          iStart;
   logic          iAbort;
   logic          iBit;
   logic          iBitVld;
   logic          oClr;
   logic          oBusy;
   logic [BW-1:0] oData;
   logic          oSat;
   logic          oValid;
   logic          iReady;

   int            cmpCnt = 0;
   int            errCnt = 0;
   logic [BW:0]   sbQueue[$];

   unary_to_binary_acc #(.BITWIDTH(BW)) dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iStart (iStart),
      .iAbort (iAbort),
      .iBit   (iBit),
      .iBitVld(iBitVld),
      .oClr   (oClr),
      .oBusy  (oBusy),
      .oData  (oData),
      .oSat   (oSat),
      .oValid (oValid),
      .iReady (iReady)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      cmpCnt++;
      assert (observed === expected) else begin
         errCnt++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Model: popcount of the window, clamped to all-ones with the saturation flag.
   function automatic logic [BW:0] modelResult(input logic [15:0] pat);
      int ones;
      ones = 0;
      for (int i = 0; i < 16; i++) ones += int'(pat[i]);
      if (ones == 16) return {1'b1, 4'hF};
      return {1'b0, 4'(ones)};
   endfunction

   task automatic applyStimulus(input logic start, input logic vld, input logic b);
      iStart  = start;
      iBitVld = vld;
      iBit    = b;
   endtask

   // The accept cycle also presents a valid 1, which must not be counted.
   task automatic startWindow(input string tag);
      applyStimulus(1'b1, 1'b1, 1'b1);
      #1;
      checkOutput({tag, "_clr_accept"}, oClr, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      #1;
      checkOutput({tag, "_clr_single"}, oClr, 0);
      checkOutput({tag, "_busy"}, oBusy, 1);
   endtask

   task automatic runWindow(input string tag, input logic [15:0] pat, input int gaps,
                            input int expRise);
      int cyc;
      int rise;
      cyc  = 0;
      rise = -1;
      sbQueue.push_back(modelResult(pat));
      for (int i = 0; i < 16; i++) begin
         if (i < gaps) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            cyc++;
            if (oValid && rise < 0) rise = cyc;
         end
         applyStimulus(1'b0, 1'b1, pat[i]);
         tick();
         cyc++;
         if (oValid && rise < 0) rise = cyc;
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 40 && rise < 0; w++) begin
         tick();
         cyc++;
         if (oValid) rise = cyc;
      end
      checkOutput({tag, "_latency"}, rise, expRise);
   endtask

   task automatic getResult(input string tag);
      logic [BW:0] exp;
      checkOutput({tag, "_valid"}, oValid, 1);
      checkOutput({tag, "_sb_nonempty"}, (sbQueue.size() > 0), 1);
      if (sbQueue.size() > 0) begin
         exp = sbQueue.pop_front();
         checkOutput({tag, "_data"}, oData, exp[BW-1:0]);
         checkOutput({tag, "_sat"}, oSat, exp[BW]);
         iReady = 1'b1;
         tick();
         iReady = 1'b0;
         #1;
         checkOutput({tag, "_valid_drop"}, oValid, 0);
         checkOutput({tag, "_data_kept"}, oData, exp[BW-1:0]);
         checkOutput({tag, "_idle"}, oBusy, 0);
      end
   endtask

   initial begin
      logic [BW:0] held;
      iRstN  = 1'b0;
      iAbort = 1'b0;
      iReady = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      #3;
      checkOutput("rst_clr", oClr, 0);
      checkOutput("rst_busy", oBusy, 0);
      checkOutput("rst_valid", oValid, 0);
      checkOutput("rst_data", oData, 0);
      checkOutput("rst_sat", oSat, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      iRstN = 1'b1;
      tick();

      startWindow("ones");
      runWindow("ones", 16'hFFFF, 0, 16);
      getResult("ones");

      startWindow("alt");
      runWindow("alt", 16'h5555, 0, 16);
      getResult("alt");

      startWindow("zero");
      runWindow("zero", 16'h0000, 0, 16);
      getResult("zero");

      startWindow("gaps");
      runWindow("gaps", 16'hFFFF, 10, 26);
      getResult("gaps");

      // Result held while the consumer stalls; a start during the hold must be dropped.
      startWindow("hold");
      runWindow("hold", 16'h0FFF, 0, 16);
      held = sbQueue[0];
      for (int c = 0; c < 20; c++) begin
         applyStimulus(c == 5, 1'b0, 1'b0);
         #1;
         if (c == 5) checkOutput("hold_no_clr", oClr, 0);
         checkOutput("hold_valid", oValid, 1);
         checkOutput("hold_data", oData, held[BW-1:0]);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("hold_start_ignored", oBusy, 0);
      iReady = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      #1;
      checkOutput("b2b_clr", oClr, 1);
      checkOutput("b2b_data", oData, held[BW-1:0]);
      checkOutput("b2b_sat", oSat, held[BW]);
      void'(sbQueue.pop_front());
      tick();
      iReady = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("b2b_valid_drop", oValid, 0);
      checkOutput("b2b_busy", oBusy, 1);
      runWindow("b2b", 16'h8001, 0, 16);
      getResult("b2b");

      startWindow("abort7");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         tick();
      end
      iAbort = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      iAbort = 1'b0;
      checkOutput("abort7_idle", oBusy, 0);
      checkOutput("abort7_valid", oValid, 0);

      startWindow("abort16");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         tick();
      end
      iAbort = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick();
      iAbort = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abort16_idle", oBusy, 0);
      for (int c = 0; c < 4; c++) begin
         checkOutput("abort16_no_valid", oValid, 0);
         tick();
      end

      startWindow("fresh");
      runWindow("fresh", 16'h00F0, 0, 16);
      getResult("fresh");

      startWindow("midrst");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         tick();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      iRstN = 1'b0;
      #1;
      checkOutput("midrst_busy", oBusy, 0);
      checkOutput("midrst_valid", oValid, 0);
      checkOutput("midrst_data", oData, 0);
      checkOutput("midrst_sat", oSat, 0);
      checkOutput("midrst_clr", oClr, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      iRstN = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         checkOutput("midrst_no_valid", oValid, 0);
      end
      startWindow("after_rst");
      runWindow("after_rst", 16'hFFFF, 0, 16);
      getResult("after_rst");

      checkOutput("sb_empty", sbQueue.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end

endmodule
